// File: rtl/cdb_bus_scheduler_if.sv
// Request/grant bundle between the execution combos and the CDB scheduler.
interface cdb_bus_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8
);
  logic                  i_flush;
  logic [NUM_REQ-1:0]    i_get_bus;
  logic [1:0]            i_bus_stall;
  logic [NUM_REQ-1:0]    o_bus_granted;
  logic [NUM_REQ-1:0]    o_bus_selected;
  logic [1:0]            o_bus_valid;
  logic [2*ADDR_W-1:0]   o_bus_owner;

  modport master (
    output i_flush, i_get_bus, i_bus_stall,
    input  o_bus_granted, o_bus_selected, o_bus_valid, o_bus_owner
  );

  modport slave (
    input  i_flush, i_get_bus, i_bus_stall,
    output o_bus_granted, o_bus_selected, o_bus_valid, o_bus_owner
  );
endinterface

// File: rtl/cdb_bus_scheduler.sv
// Round-robin scheduler granting up to two requesters per cycle onto CDB0/CDB1.
// Optional request aging is enabled by defining CDB_SCHED_AGING_EN.
module cdb_bus_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int AGE_LIMIT = 7
) (
  input  logic                i_clock,
  input  logic                i_reset,
  cdb_bus_scheduler_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (AGE_LIMIT < 1 || AGE_LIMIT > 7) begin : g_bad_age_limit
    $error("AGE_LIMIT must fit the 3-bit age counter");
  end

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   mask_q, mask_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   sel_q, sel_d;
  logic [1:0]           valid_q, valid_d;
  logic [2*ADDR_W-1:0]  owner_q, owner_d;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   aged;
  int                   n_free;
  int                   n_hit;
  int                   idx;
  int                   bus_idx;

  // Pass 0 visits aged requesters, pass 1 the rest; both in rotation from ptr_q.
  always_comb begin
    elig    = bus.i_get_bus & ~mask_q;
    grant_d = '0;
    sel_d   = '0;
    valid_d = '0;
    owner_d = '1;
    ptr_d   = ptr_q;
    n_free  = (bus.i_bus_stall[0] ? 0 : 1) + (bus.i_bus_stall[1] ? 0 : 1);
    n_hit   = 0;
    idx     = 0;
    bus_idx = 0;
    if (!bus.i_flush) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          idx = (int'(ptr_q) + i) % NUM_REQ;
          if (elig[idx] && (aged[idx] == (pass == 0)) && (n_hit < n_free)) begin
            bus_idx = (n_hit == 0 && !bus.i_bus_stall[0]) ? 0 : 1;
            grant_d[idx]   = 1'b1;
            sel_d[idx]     = bus_idx[0];
            valid_d[bus_idx] = 1'b1;
            owner_d[bus_idx*ADDR_W +: ADDR_W] = ADDR_W'(idx);
            ptr_d          = PTR_W'((idx + 1) % NUM_REQ);
            n_hit          = n_hit + 1;
          end
        end
      end
    end
    // A fully stalled cycle leaves the turnaround mask untouched.
    if (bus.i_flush)
      mask_d = '0;
    else if (n_free == 0)
      mask_d = mask_q;
    else
      mask_d = grant_d;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ptr_q   <= '0;
      mask_q  <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= '0;
      owner_q <= '1;
    end else begin
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

`ifdef CDB_SCHED_AGING_EN
  logic [2:0] age_q [NUM_REQ];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_REQ; k++) age_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.i_flush || grant_d[k] || !bus.i_get_bus[k])
          age_q[k] <= '0;
        else if (elig[k] && age_q[k] != 3'd7)
          age_q[k] <= age_q[k] + 3'd1;
      end
    end
  end

  always_comb begin
    aged = '0;
    for (int k = 0; k < NUM_REQ; k++) aged[k] = (int'(age_q[k]) >= AGE_LIMIT);
  end
`else
  assign aged = '0;
`endif

  assign bus.o_bus_granted  = grant_q;
  assign bus.o_bus_selected = sel_q;
  assign bus.o_bus_valid    = valid_q;
  assign bus.o_bus_owner    = owner_q;
endmodule

// File: tb/tb_cdb_bus_scheduler.sv
// Self-checking bench for cdb_bus_scheduler: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cdb_bus_scheduler;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int AL = 7;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;

  cdb_bus_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

  cdb_bus_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .AGE_LIMIT(AL)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;

  int               m_ptr;
  bit               m_mask [NR];
  int               m_age  [NR];
  logic [NR-1:0]    e_grant, e_sel;
  logic [1:0]       e_valid;
  logic [2*AW-1:0]  e_owner;

  task automatic model_reset();
    m_ptr = 0;
    for (int k = 0; k < NR; k++) begin
      m_mask[k] = 1'b0;
      m_age[k]  = 0;
    end
    e_grant = '0;
    e_sel   = '0;
    e_valid = '0;
    e_owner = '1;
  endtask

  function automatic bit is_aged(int k);
`ifdef CDB_SCHED_AGING_EN
    return m_age[k] >= AL;
`else
    return 1'b0;
`endif
  endfunction

  // Next-cycle expectation from the arbitration rules, using current inputs.
  task automatic model_step();
    int order[$];
    int buses[$];
    int ng;
    e_grant = '0;
    e_sel   = '0;
    e_valid = '0;
    e_owner = '1;
    if (bus.i_flush) begin
      for (int k = 0; k < NR; k++) begin
        m_mask[k] = 1'b0;
        m_age[k]  = 0;
      end
      return;
    end
    for (int b = 0; b < 2; b++)
      if (!bus.i_bus_stall[b]) buses.push_back(b);
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (m_ptr + i) % NR;
        if (bus.i_get_bus[k] && !m_mask[k] && (is_aged(k) == (pass == 0)))
          order.push_back(k);
      end
    ng = (order.size() < buses.size()) ? order.size() : buses.size();
    for (int j = 0; j < ng; j++) begin
      int k;
      int b;
      k = order[j];
      b = buses[j];
      e_grant[k] = 1'b1;
      e_sel[k]   = b[0];
      e_valid[b] = 1'b1;
      e_owner[b*AW +: AW] = AW'(k);
    end
    if (ng > 0) m_ptr = (order[ng-1] + 1) % NR;
    for (int k = 0; k < NR; k++) begin
      if (e_grant[k] || !bus.i_get_bus[k]) m_age[k] = 0;
      else if (!m_mask[k] && m_age[k] < 7) m_age[k] = m_age[k] + 1;
    end
    if (buses.size() != 0)
      for (int k = 0; k < NR; k++) m_mask[k] = e_grant[k];
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_flush     = 1'b0;
    bus.i_get_bus   = '0;
    bus.i_bus_stall = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge i_clock);
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 i_reset = 1'b1;
    #2;
    total++; if (bus.o_bus_granted !== 4'b0000) begin bad++; $display("FAIL reset_granted got=%b want=0000", bus.o_bus_granted); end
    total++; if (bus.o_bus_selected !== 4'b0000) begin bad++; $display("FAIL reset_selected got=%b want=0000", bus.o_bus_selected); end
    total++; if (bus.o_bus_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", bus.o_bus_valid); end
    total++; if (bus.o_bus_owner !== 16'hFFFF) begin bad++; $display("FAIL reset_owner got=%h want=ffff", bus.o_bus_owner); end
    model_reset();
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.i_get_bus = 4'b0100;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0100) begin bad++; $display("FAIL single_granted got=%b want=0100", bus.o_bus_granted); end
    total++; if (bus.o_bus_selected[2] !== 1'b0) begin bad++; $display("FAIL single_selected got=%b want=0", bus.o_bus_selected[2]); end
    total++; if (bus.o_bus_valid !== 2'b01) begin bad++; $display("FAIL single_valid got=%b want=01", bus.o_bus_valid); end
    total++; if (bus.o_bus_owner !== 16'hFF02) begin bad++; $display("FAIL single_owner got=%h want=ff02", bus.o_bus_owner); end
    bus.i_get_bus = 4'b0000;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0000) begin bad++; $display("FAIL idle_granted got=%b want=0000", bus.o_bus_granted); end
    total++; if (bus.o_bus_owner !== 16'hFFFF) begin bad++; $display("FAIL idle_owner got=%h want=ffff", bus.o_bus_owner); end
    // Pointer is now 3: scan wraps 3 -> 0.
    bus.i_get_bus = 4'b1111;
    tick();
    total++; if (bus.o_bus_granted !== 4'b1001) begin bad++; $display("FAIL wrap_granted got=%b want=1001", bus.o_bus_granted); end
    total++; if (bus.o_bus_owner !== 16'h0003) begin bad++; $display("FAIL wrap_owner got=%h want=0003", bus.o_bus_owner); end
    total++; if (bus.o_bus_selected !== 4'b0001) begin bad++; $display("FAIL wrap_selected got=%b want=0001", bus.o_bus_selected); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] prev;
    logic [NR-1:0] want_g;
    logic [15:0]   want_o;
    do_reset();
    bus.i_get_bus = 4'b1111;
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      want_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      want_o = (c % 2 == 0) ? 16'h0100 : 16'h0302;
      total++; if (bus.o_bus_granted !== want_g) begin bad++; $display("FAIL rr_granted cyc=%0d got=%b want=%b", c, bus.o_bus_granted, want_g); end
      total++; if (bus.o_bus_owner !== want_o) begin bad++; $display("FAIL rr_owner cyc=%0d got=%h want=%h", c, bus.o_bus_owner, want_o); end
      total++; if ((bus.o_bus_granted & prev) !== 4'b0000) begin bad++; $display("FAIL rr_repeat cyc=%0d got=%b want=0000", c, bus.o_bus_granted & prev); end
      prev = bus.o_bus_granted;
    end
    clear_inputs();
  endtask

  task automatic test_stall_one();
    do_reset();
    bus.i_get_bus   = 4'b0011;
    bus.i_bus_stall = 2'b01;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0001) begin bad++; $display("FAIL stall1_granted got=%b want=0001", bus.o_bus_granted); end
    total++; if (bus.o_bus_valid !== 2'b10) begin bad++; $display("FAIL stall1_valid got=%b want=10", bus.o_bus_valid); end
    total++; if (bus.o_bus_owner !== 16'h00FF) begin bad++; $display("FAIL stall1_owner got=%h want=00ff", bus.o_bus_owner); end
    total++; if (bus.o_bus_selected !== 4'b0001) begin bad++; $display("FAIL stall1_selected got=%b want=0001", bus.o_bus_selected); end
    bus.i_get_bus   = 4'b0010;
    bus.i_bus_stall = 2'b00;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0010) begin bad++; $display("FAIL stall1_next_granted got=%b want=0010", bus.o_bus_granted); end
    total++; if (bus.o_bus_owner !== 16'hFF01) begin bad++; $display("FAIL stall1_next_owner got=%h want=ff01", bus.o_bus_owner); end
    clear_inputs();
  endtask

  task automatic test_stall_both();
    do_reset();
    bus.i_get_bus = 4'b0100;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0100) begin bad++; $display("FAIL stall2_setup got=%b want=0100", bus.o_bus_granted); end
    bus.i_get_bus   = 4'b1111;
    bus.i_bus_stall = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.o_bus_granted !== 4'b0000) begin bad++; $display("FAIL stall2_granted cyc=%0d got=%b want=0000", c, bus.o_bus_granted); end
      total++; if (bus.o_bus_owner !== 16'hFFFF) begin bad++; $display("FAIL stall2_owner cyc=%0d got=%h want=ffff", c, bus.o_bus_owner); end
    end
    bus.i_bus_stall = 2'b00;
    tick();
    total++; if (bus.o_bus_granted !== 4'b1001) begin bad++; $display("FAIL stall2_release got=%b want=1001", bus.o_bus_granted); end
    total++; if (bus.o_bus_owner !== 16'h0003) begin bad++; $display("FAIL stall2_release_owner got=%h want=0003", bus.o_bus_owner); end
    clear_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    bus.i_get_bus = 4'b0010;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0010) begin bad++; $display("FAIL flush_setup got=%b want=0010", bus.o_bus_granted); end
    bus.i_get_bus = 4'b1111;
    bus.i_flush   = 1'b1;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0000) begin bad++; $display("FAIL flush_granted got=%b want=0000", bus.o_bus_granted); end
    total++; if (bus.o_bus_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b want=00", bus.o_bus_valid); end
    total++; if (bus.o_bus_owner !== 16'hFFFF) begin bad++; $display("FAIL flush_owner got=%h want=ffff", bus.o_bus_owner); end
    bus.i_flush = 1'b0;
    tick();
    total++; if (bus.o_bus_granted !== 4'b1100) begin bad++; $display("FAIL flush_resume got=%b want=1100", bus.o_bus_granted); end
    total++; if (bus.o_bus_owner !== 16'h0302) begin bad++; $display("FAIL flush_resume_owner got=%h want=0302", bus.o_bus_owner); end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_get_bus = 4'b1111;
    tick();
    total++; if (bus.o_bus_granted !== 4'b0011) begin bad++; $display("FAIL areset_setup got=%b want=0011", bus.o_bus_granted); end
    #2 i_reset = 1'b1;
    #1;
    total++; if (bus.o_bus_granted !== 4'b0000) begin bad++; $display("FAIL areset_granted got=%b want=0000", bus.o_bus_granted); end
    total++; if (bus.o_bus_valid !== 2'b00) begin bad++; $display("FAIL areset_valid got=%b want=00", bus.o_bus_valid); end
    total++; if (bus.o_bus_owner !== 16'hFFFF) begin bad++; $display("FAIL areset_owner got=%h want=ffff", bus.o_bus_owner); end
    total++; if (bus.o_bus_selected !== 4'b0000) begin bad++; $display("FAIL areset_selected got=%b want=0000", bus.o_bus_selected); end
    #1 i_reset = 1'b0;
    model_reset();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.i_get_bus   = 4'($urandom_range(0, 15));
      bus.i_bus_stall = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      bus.i_flush     = ($urandom_range(0, 19) == 0);
      tick();
      total++; if (bus.o_bus_granted !== e_grant) begin bad++; $display("FAIL rand_granted n=%0d got=%b want=%b", n, bus.o_bus_granted, e_grant); end
      total++; if (bus.o_bus_valid !== e_valid) begin bad++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, bus.o_bus_valid, e_valid); end
      total++; if (bus.o_bus_owner !== e_owner) begin bad++; $display("FAIL rand_owner n=%0d got=%h want=%h", n, bus.o_bus_owner, e_owner); end
      total++; if ((bus.o_bus_selected & bus.o_bus_granted) !== e_sel) begin bad++; $display("FAIL rand_selected n=%0d got=%b want=%b", n, bus.o_bus_selected & bus.o_bus_granted, e_sel); end
      total++; if ($countones(bus.o_bus_granted) != $countones(bus.o_bus_valid)) begin bad++; $display("FAIL rand_popcount n=%0d got=%0d want=%0d", n, $countones(bus.o_bus_granted), $countones(bus.o_bus_valid)); end
    end
    clear_inputs();
  endtask

`ifdef CDB_SCHED_AGING_EN
  task automatic test_aging();
    int waited;
    bit got;
    do_reset();
    bus.i_get_bus   = 4'b1111;
    bus.i_bus_stall = 2'b10;
    waited = 0;
    got    = 1'b0;
    for (int c = 0; c < AL + 4 && !got; c++) begin
      tick();
      if (bus.o_bus_granted[3]) got = 1'b1;
      else waited++;
    end
    total++; if (!got || waited + 1 > AL + 1) begin bad++; $display("FAIL aging_wait got=%0d want<=%0d", waited + 1, AL + 1); end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall_one();
    test_stall_both();
    test_flush();
    test_async_reset();
    test_random();
`ifdef CDB_SCHED_AGING_EN
    test_aging();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_bus_scheduler.md
Name: cdb_bus_scheduler

Overview:
- Central scheduler that shares the two common data buses (CDB0, CDB1) between the execution combos (ALU, branch, mult/div, load/store).
- Each combo raises a bus request when its result is ready. The scheduler grants up to two requesters per cycle with round-robin fairness, tells each winner which bus to drive, and drives the per-bus owner select consumed by the bus muxes.
- Supports per-bus stall (ROB back-pressure) and pipeline flush.

Parameters:
- NUM_REQ, 4, number of requesting combos; requester k has bus address k.
- ADDR_W, 8, width of the per-bus owner address.
- AGE_LIMIT, 7, wait cycles after which a request is promoted (only with the optional feature).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous flush: drop all pending and in-flight grants.
- i_get_bus  in  NUM_REQ  per-requester bus request (level, held until granted).
- i_bus_stall  in  2  per-bus stall; a stalled bus receives no new grant.
- o_bus_granted  out  NUM_REQ  one-cycle grant pulse per requester.
- o_bus_selected  out  NUM_REQ  bus index for the granted requester (0 = CDB0, 1 = CDB1); valid only with the grant.
- o_bus_valid  out  2  bus b carries a granted result this cycle.
- o_bus_owner  out  2*ADDR_W  owner address per bus, bus b in bits [b*ADDR_W +: ADDR_W]; all-ones when the bus is idle.

Behaviour:
- Reset (asynchronous) values:
  - o_bus_granted = 0, o_bus_selected = 0, o_bus_valid = 0, o_bus_owner = all ones.
  - rr pointer = 0, masked set = 0, age counters = 0.
- Latency: request sampled at edge t, grant registered and visible in cycle t+1. The requester drives its result on the selected bus during the grant cycle.
- Eligibility: requester k is eligible when i_get_bus[k] = 1 and k was not granted in the current cycle (masked set). The mask covers the one-cycle turnaround before the requester drops its request. A requester still requesting one cycle after its grant is eligible again; this is legal for back-to-back results.
- Arbitration:
  - Scan eligible requesters circularly starting at the rr pointer.
  - The first hit goes to the lowest-numbered non-stalled bus; the second hit goes to the remaining non-stalled bus.
  - Nothing is assigned to a stalled bus. With both buses stalled, no grants are issued and the pointer and masked set hold.
- Pointer update: after a cycle with at least one grant, pointer = (index of last granted requester + 1) mod NUM_REQ. Otherwise it is unchanged.
- Exclusivity:
  - At most one requester per bus per cycle.
  - A requester never gets both buses in one cycle.
  - popcount(o_bus_granted) equals popcount(o_bus_valid), and is at most 2.
- Owner: when o_bus_valid[b] = 1, o_bus_owner[b] = granted index zero-extended to ADDR_W. Otherwise it is all ones.
- Flush:
  - i_flush high at edge t gives o_bus_granted = 0 and o_bus_valid = 0 in cycle t+1, and clears the masked set and age counters.
  - The rr pointer is kept.
  - A flush has priority over any simultaneous request.
- Requests with i_get_bus low are ignored. A request dropped before its grant is simply lost; no error is raised.
- Reset asserted mid-grant: outputs go to reset values immediately, without waiting for a clock edge.
- Wrap-around: with the pointer at NUM_REQ-1, the scan continues through 0 and upward.

Optional Feature:
- Macro: CDB_SCHED_AGING_EN.
- Defined:
  - Each requester has a 3-bit saturating age counter. It increments each cycle the requester is eligible but not granted, and clears on grant, flush or request drop.
  - Requesters with age >= AGE_LIMIT are scanned first, in round-robin order among themselves, ahead of all others.
  - Worst-case wait is AGE_LIMIT+1 cycles whenever a bus is free.
- Undefined: no counters are synthesized; pure round-robin as above.

Test Plan:
- Reset, then single request i_get_bus = 4'b0100 → cycle+1: o_bus_granted = 4'b0100, o_bus_selected[2] = 0, o_bus_valid = 2'b01, owner0 = 8'h02, owner1 = 8'hFF; pointer becomes 3.
- All four requests held continuously from pointer 0 → grants {0,1}, {2,3}, {0,1}, ... each pair on buses 0/1; never the same index twice in consecutive cycles.
- i_get_bus = 4'b0011 with i_bus_stall = 2'b01 → only requester 0 granted, on bus 1 (owner1 = 8'h00, o_bus_valid = 2'b10); requester 1 granted next cycle once the stall clears.
- i_bus_stall = 2'b11 for 3 cycles with requests pending → no grants and pointer unchanged; the first cycle after the stall releases grants from the saved pointer.
- i_flush in the same cycle as i_get_bus = 4'b1111 → next cycle all grant outputs 0; arbitration resumes the following cycle.
- i_reset asserted asynchronously between edges during a grant → outputs drop to reset values before the next edge. With CDB_SCHED_AGING_EN: requester 3 starved by 0/1/2 is granted within AGE_LIMIT+1 cycles.
